// File: rtl/demux_10_seq_ctrl.sv
// Sequencer for the 1-to-NUM_OUT score demux: routes one frame of NUM_OUT
// words to consecutive destinations, then waits for a downstream ack.
module demux_10_seq_ctrl #(
  parameter int unsigned DATA_W  = 7,
  parameter int unsigned NUM_OUT = 10,
  parameter int unsigned SEL_W   = 4,
  parameter int unsigned FCNT_W  = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DATA_W-1:0]  din,
  input  logic               out_ack,
  output logic [SEL_W-1:0]   sel,
  output logic [DATA_W-1:0]  dout_data,
  output logic [NUM_OUT-1:0] dout_wr_en,
  output logic               frame_done,
  output logic               busy,
  output logic [FCNT_W-1:0]  frame_cnt
);

  localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(NUM_OUT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ROUTE = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [SEL_W-1:0]   r_idx;
  logic [SEL_W-1:0]   w_idx_nxt;
  logic               w_accept;
  logic               w_last;

  logic [SEL_W-1:0]   r_sel;
  logic [DATA_W-1:0]  r_dout_data;
  logic [NUM_OUT-1:0] r_dout_wr_en;
  logic               r_frame_done;
  logic [FCNT_W-1:0]  r_frame_cnt;

  // Handshake status is a pure function of the current state
  assign in_ready = (r_state != S_HOLD);
  assign busy     = (r_state != S_IDLE);
  assign w_accept = in_valid && (r_state != S_HOLD);
  assign w_last   = w_accept && (r_state == S_ROUTE) && (r_idx == LAST_IDX);

  // State and word-index register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  // Next-state and index update
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    unique case (r_state)
      S_IDLE: begin
        w_idx_nxt = '0;
        if (w_accept) begin
          w_idx_nxt   = SEL_W'(1);
          w_state_nxt = S_ROUTE;
        end
      end
      S_ROUTE: begin
        if (w_accept) begin
          if (r_idx == LAST_IDX) begin
            w_idx_nxt   = '0;
            w_state_nxt = S_HOLD;
          end else begin
            w_idx_nxt = r_idx + SEL_W'(1);
          end
        end
      end
      S_HOLD: begin
        w_idx_nxt = '0;
        if (out_ack) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_idx_nxt   = '0;
      end
    endcase
  end

  // Registered demux outputs: one strobe per accepted word, one cycle later
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sel        <= '0;
      r_dout_data  <= '0;
      r_dout_wr_en <= '0;
      r_frame_done <= 1'b0;
      r_frame_cnt  <= '0;
    end else begin
      r_dout_wr_en <= '0;
      r_frame_done <= w_last;
      if (w_accept) begin
        r_sel        <= r_idx;
        r_dout_data  <= din;
        r_dout_wr_en <= NUM_OUT'(1) << r_idx;
      end
      if (w_last) begin
        r_frame_cnt <= r_frame_cnt + FCNT_W'(1);
      end
    end
  end

  assign sel        = r_sel;
  assign dout_data  = r_dout_data;
  assign dout_wr_en = r_dout_wr_en;
  assign frame_done = r_frame_done;
  assign frame_cnt  = r_frame_cnt;

endmodule
